// File: rtl/pci_avm_burst_splitter_if.sv
// Avalon-MM bus bundle around the burst splitter: upstream burst port (s_*)
// and downstream single-beat PCI bridge port (m_*).
interface pci_avm_burst_splitter_if #(
  parameter int ADDR_W  = 30,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]  s_address;
  logic [31:0]        s_writedata;
  logic [3:0]         s_byteenable;
  logic [BURST_W-1:0] s_burstcount;
  logic               s_write;
  logic               s_read;
  logic               s_waitrequest;
  logic               s_readdatavalid;
  logic [31:0]        s_readdata;

  logic [ADDR_W-1:0]  m_address;
  logic [31:0]        m_writedata;
  logic [3:0]         m_byteenable;
  logic               m_write;
  logic               m_read;
  logic               m_waitrequest;
  logic               m_readdatavalid;
  logic [31:0]        m_readdata;

  // The splitter itself: upstream slave, downstream requester.
  modport slave (
    input  s_address, s_writedata, s_byteenable, s_burstcount, s_write, s_read,
    output s_waitrequest, s_readdatavalid, s_readdata,
    output m_address, m_writedata, m_byteenable, m_write, m_read,
    input  m_waitrequest, m_readdatavalid, m_readdata
  );

  // The environment: CPU master upstream plus the PCI bridge downstream.
  modport master (
    output s_address, s_writedata, s_byteenable, s_burstcount, s_write, s_read,
    input  s_waitrequest, s_readdatavalid, s_readdata,
    input  m_address, m_writedata, m_byteenable, m_write, m_read,
    output m_waitrequest, m_readdatavalid, m_readdata
  );
endinterface

// File: rtl/pci_avm_burst_splitter.sv
// Splits upstream Avalon bursts (1..15 beats) into single-word transactions
// for the PCI host bridge, one outstanding at a time, and streams read data back.
module pci_avm_burst_splitter #(
  parameter int ADDR_W  = 30,
  parameter int BURST_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pci_avm_burst_splitter_if.slave        bus,
  output logic                           busy,
  output logic                           proto_err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ISSUE = 3'd1;
  localparam logic [2:0] WR_FETCH = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0]  m_address_q, m_address_d;
  logic [31:0]        m_writedata_q, m_writedata_d;
  logic [3:0]         m_byteenable_q, m_byteenable_d;
  logic               m_write_q, m_write_d;
  logic               m_read_q, m_read_d;
  logic               s_readdatavalid_q, s_readdatavalid_d;
  logic [31:0]        s_readdata_q, s_readdata_d;
  logic               proto_err_q, proto_err_d;
  logic [BURST_W-1:0] burst_len;

  // A burstcount of zero is serviced as a single beat.
  always_comb begin
    burst_len = (bus.s_burstcount == '0) ? BURST_W'(1) : bus.s_burstcount;
  end

  always_comb begin
    state_d           = state_q;
    remaining_d       = remaining_q;
    m_address_d       = m_address_q;
    m_writedata_d     = m_writedata_q;
    m_byteenable_d    = m_byteenable_q;
    m_write_d         = m_write_q;
    m_read_d          = m_read_q;
    s_readdatavalid_d = 1'b0;
    s_readdata_d      = s_readdata_q;
    proto_err_d       = proto_err_q;

    case (state_q)
      IDLE: begin
        if (bus.s_write) begin
          m_address_d    = bus.s_address;
          m_writedata_d  = bus.s_writedata;
          m_byteenable_d = bus.s_byteenable;
          remaining_d    = burst_len - BURST_W'(1);
          m_write_d      = 1'b1;
          state_d        = WR_ISSUE;
          if (bus.s_read) proto_err_d = 1'b1;
        end else if (bus.s_read) begin
          m_address_d    = bus.s_address;
          m_byteenable_d = 4'hF;
          remaining_d    = burst_len;
          m_read_d       = 1'b1;
          state_d        = RD_ISSUE;
        end
      end

      WR_ISSUE: begin
        if (!bus.m_waitrequest) begin
          m_write_d = 1'b0;
          if (remaining_q == '0) begin
            state_d = IDLE;
          end else begin
            m_address_d = m_address_q + ADDR_W'(1);
            state_d     = WR_FETCH;
          end
        end
      end

      // Next write beat is taken from upstream here; reads are not accepted.
      WR_FETCH: begin
        if (bus.s_write) begin
          m_writedata_d  = bus.s_writedata;
          m_byteenable_d = bus.s_byteenable;
          remaining_d    = remaining_q - BURST_W'(1);
          m_write_d      = 1'b1;
          state_d        = WR_ISSUE;
        end
      end

      RD_ISSUE: begin
        if (!bus.m_waitrequest) begin
          m_read_d = 1'b0;
          state_d  = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.m_readdatavalid) begin
          s_readdatavalid_d = 1'b1;
          s_readdata_d      = bus.m_readdata;
          remaining_d       = remaining_q - BURST_W'(1);
          if (remaining_q == BURST_W'(1)) begin
            state_d = IDLE;
          end else begin
            m_address_d    = m_address_q + ADDR_W'(1);
            m_byteenable_d = 4'hF;
            m_read_d       = 1'b1;
            state_d        = RD_ISSUE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        m_write_d = 1'b0;
        m_read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      remaining_q       <= '0;
      m_address_q       <= '0;
      m_writedata_q     <= '0;
      m_byteenable_q    <= '0;
      m_write_q         <= 1'b0;
      m_read_q          <= 1'b0;
      s_readdatavalid_q <= 1'b0;
      s_readdata_q      <= '0;
      proto_err_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      remaining_q       <= remaining_d;
      m_address_q       <= m_address_d;
      m_writedata_q     <= m_writedata_d;
      m_byteenable_q    <= m_byteenable_d;
      m_write_q         <= m_write_d;
      m_read_q          <= m_read_d;
      s_readdatavalid_q <= s_readdatavalid_d;
      s_readdata_q      <= s_readdata_d;
      proto_err_q       <= proto_err_d;
    end
  end

  assign bus.s_waitrequest   = !((state_q == IDLE) || (state_q == WR_FETCH));
  assign bus.s_readdatavalid = s_readdatavalid_q;
  assign bus.s_readdata      = s_readdata_q;
  assign bus.m_address       = m_address_q;
  assign bus.m_writedata     = m_writedata_q;
  assign bus.m_byteenable    = m_byteenable_q;
  assign bus.m_write         = m_write_q;
  assign bus.m_read          = m_read_q;
  assign busy                = (state_q != IDLE);
  assign proto_err           = proto_err_q;

endmodule

// File: tb/tb_pci_avm_burst_splitter.sv
// Scoreboard bench for pci_avm_burst_splitter: directed bursts, a behavioural
// PCI bridge, and a negedge monitor that checks every downstream/upstream beat.
`timescale 1ns/1ps
module tb_pci_avm_burst_splitter;
  localparam int ADDR_W  = 30;
  localparam int BURST_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, proto_err;

  always #5 clk = ~clk;

  pci_avm_burst_splitter_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  pci_avm_burst_splitter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .proto_err(proto_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rd_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_ra[$];
  rd_t               exp_rd[$];
  logic [31:0]       br_data[$];

  int errors = 0;
  int checks = 0;

  int br_wait = 0;
  int br_lat  = 3;
  int br_cnt  = 0;
  int rd_cnt  = 0;
  bit rd_pend = 1'b0;

  int   rd_acc     = 0;
  bit   fetch_seen = 1'b0;
  logic last_mrdv  = 1'b0;
  wr_t  mon_w;
  logic [ADDR_W-1:0] mon_a;
  rd_t  mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bridge model: holds waitrequest br_wait cycles per request, returns read data br_lat cycles after acceptance.
  initial begin
    bus.m_waitrequest   = 1'b1;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      bus.m_readdatavalid = 1'b0;
      if (!rst_n) begin
        rd_pend           = 1'b0;
        br_cnt            = 0;
        bus.m_waitrequest = 1'b1;
        br_data.delete();
      end else begin
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = (br_data.size() != 0) ? br_data.pop_front() : 32'hFFFF_FFFF;
            rd_pend             = 1'b0;
          end else begin
            rd_cnt--;
          end
        end
        if (bus.m_read || bus.m_write) begin
          if (br_cnt < br_wait) begin
            bus.m_waitrequest = 1'b1;
            br_cnt++;
          end else begin
            bus.m_waitrequest = 1'b0;
            br_cnt = 0;
            if (bus.m_read) begin
              rd_pend = 1'b1;
              rd_cnt  = br_lat;
            end
          end
        end else begin
          bus.m_waitrequest = 1'b1;
          br_cnt = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_write && !bus.m_waitrequest) begin
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", bus.m_address, mon_w.addr);
          chk("wr_data", bus.m_writedata, mon_w.data);
          chk("wr_be", bus.m_byteenable, mon_w.be);
        end
      end
      if (bus.m_read && !bus.m_waitrequest) begin
        rd_acc++;
        chk("rd_expected", exp_ra.size() != 0, 1);
        if (exp_ra.size() != 0) begin
          mon_a = exp_ra.pop_front();
          chk("rd_addr", bus.m_address, mon_a);
          chk("rd_be", bus.m_byteenable, 4'hF);
        end
      end
      if (bus.s_readdatavalid) begin
        chk("rdata_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          mon_r = exp_rd.pop_front();
          chk("rdata", bus.s_readdata, mon_r.data);
          chk("busy_at_rdv", busy, !mon_r.last);
        end
      end
      if (bus.s_readdatavalid || last_mrdv)
        chk("rdv_latency", bus.s_readdatavalid, last_mrdv);
      last_mrdv = bus.m_readdatavalid;
      if (bus.m_write || bus.m_read) chk("s_wait_during_req", bus.s_waitrequest, 1);
      if (!busy) chk("s_wait_idle", bus.s_waitrequest, 0);
      if (busy && !bus.s_waitrequest) fetch_seen = 1'b1;
    end else begin
      last_mrdv = 1'b0;
    end
  end

  task automatic up_accept(input string name);
    int   n;
    logic w;
    n = 0;
    do begin
      @(negedge clk);
      w = bus.s_waitrequest;
      @(posedge clk); #1;
      n++;
    end while (w && n < 200);
    chk({name, "_accept"}, w, 0);
  endtask

  task automatic up_write(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                          input int n, input logic [31:0] d[4], input logic [3:0] be[4]);
    for (int i = 0; i < n; i++) begin
      bus.s_address    = a;
      bus.s_burstcount = bc;
      bus.s_writedata  = d[i];
      bus.s_byteenable = be[i];
      bus.s_write      = 1'b1;
      exp_wr.push_back('{addr: ADDR_W'(a + ADDR_W'(i)), data: d[i], be: be[i]});
      up_accept("wr");
      bus.s_write = 1'b0;
    end
  endtask

  task automatic up_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                         input int n, input logic [31:0] d[4]);
    for (int i = 0; i < n; i++) begin
      br_data.push_back(d[i]);
      exp_ra.push_back(ADDR_W'(a + ADDR_W'(i)));
      exp_rd.push_back('{data: d[i], last: (i == n - 1)});
    end
    bus.s_address    = a;
    bus.s_burstcount = bc;
    bus.s_read       = 1'b1;
    up_accept("rd");
    bus.s_read = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_read"}, bus.m_read, 0);
    chk({tag, "_m_write"}, bus.m_write, 0);
    chk({tag, "_m_address"}, bus.m_address, 0);
    chk({tag, "_m_writedata"}, bus.m_writedata, 0);
    chk({tag, "_m_byteenable"}, bus.m_byteenable, 0);
    chk({tag, "_s_rdv"}, bus.s_readdatavalid, 0);
    chk({tag, "_s_readdata"}, bus.s_readdata, 0);
    chk({tag, "_s_wait"}, bus.s_waitrequest, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.s_address    = '0;
    bus.s_writedata  = '0;
    bus.s_byteenable = '0;
    bus.s_burstcount = '0;
    bus.s_write      = 1'b0;
    bus.s_read       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, slow bridge response.
    br_wait = 0; br_lat = 5;
    up_read(30'h0000_1000, 4'd1, 1, '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0});
    wait_idle();

    // Read burst crossing the address wrap.
    br_lat = 2;
    up_read(30'h3FFF_FFFE, 4'd4, 4, '{32'hA000_0001, 32'hA000_0002, 32'hFFFF_FFFF, 32'hA000_0004});
    wait_idle();

    // Write burst of 3 with a stalling bridge.
    br_wait = 4; br_lat = 1; fetch_seen = 1'b0;
    up_write(30'h0000_0100, 4'd3, 3, '{32'h11, 32'h22, 32'h33, 32'h0}, '{4'hF, 4'h3, 4'hC, 4'h0});
    wait_idle();
    chk("wr3_fetch_seen", fetch_seen, 1);

    // burstcount 0 write is one beat with no fetch phase.
    br_wait = 1; fetch_seen = 1'b0;
    up_write(30'h0000_2000, 4'd0, 1, '{32'h55AA_55AA, 32'h0, 32'h0, 32'h0}, '{4'h5, 4'h0, 4'h0, 4'h0});
    wait_idle();
    chk("bc0_no_fetch", fetch_seen, 0);

    // Simultaneous read and write: write wins, error becomes sticky.
    chk("proto_err_before", proto_err, 0);
    br_wait = 0;
    base = rd_acc;
    bus.s_read = 1'b1;
    up_write(30'h0000_0300, 4'd1, 1, '{32'hCAFE_0300, 32'h0, 32'h0, 32'h0}, '{4'hF, 4'h0, 4'h0, 4'h0});
    bus.s_read = 1'b0;
    wait_idle();
    chk("proto_no_read", rd_acc, base);
    chk("proto_err_set", proto_err, 1);
    up_read(30'h0000_0400, 4'd2, 2, '{32'h0400_0000, 32'h0400_0001, 32'h0, 32'h0});
    wait_idle();
    chk("proto_err_held", proto_err, 1);

    // Reset during beat 2 of a 4-beat read.
    br_wait = 0; br_lat = 3;
    base = rd_acc;
    br_data.push_back(32'hB000_0000);
    br_data.push_back(32'hB000_0001);
    exp_ra.push_back(30'h0000_0500);
    exp_ra.push_back(30'h0000_0501);
    exp_rd.push_back('{data: 32'hB000_0000, last: 1'b0});
    bus.s_address    = 30'h0000_0500;
    bus.s_burstcount = 4'd4;
    bus.s_read       = 1'b1;
    up_accept("rd_rst");
    bus.s_read = 1'b0;
    n = 0;
    while (rd_acc < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rst_beat2_reached", rd_acc >= base + 2, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    up_read(30'h0000_0600, 4'd2, 2, '{32'h0600_0000, 32'h0600_0001, 32'h0, 32'h0});
    wait_idle();
    chk("post_rst_proto_err", proto_err, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_addr_queue_drained", exp_ra.size(), 0);
    chk("rd_data_queue_drained", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_avm_burst_splitter.md
Name: pci_avm_burst_splitter

Overview:
- Sits between the CPU/SoC Avalon-MM master and the single-beat PCI host bridge.
- Accepts Avalon bursts of 1..15 words and replays them downstream as single-word read or write transactions, one outstanding at a time, with the address incrementing per beat.
- Collects downstream read data back into a registered upstream burst-read stream.
- Flags illegal upstream commands on a sticky error output.

Parameters:
ADDR_W, 30, word-address width on both sides
BURST_W, 4, burstcount width

Ports:
clk  in  1  system clock, also the PCI bridge clock
rst_n  in  1  reset, asynchronous, active-low
s_address  in  ADDR_W  upstream word address, first beat
s_writedata  in  32  upstream write data
s_byteenable  in  4  upstream byte enables, active-high
s_burstcount  in  BURST_W  burst length; 0 is treated as 1
s_write  in  1  upstream write beat
s_read  in  1  upstream read command
s_waitrequest  out  1  upstream stall
s_readdatavalid  out  1  upstream read beat valid
s_readdata  out  32  upstream read data
m_address  out  ADDR_W  word address to the PCI bridge
m_writedata  out  32  write data to the bridge
m_byteenable  out  4  byte enables to the bridge
m_write  out  1  single-word write request
m_read  out  1  single-word read request
m_waitrequest  in  1  bridge busy; a request is accepted in a cycle where it is asserted and m_waitrequest=0
m_readdatavalid  in  1  bridge read data valid
m_readdata  in  32  bridge read data
busy  out  1  high in any state other than IDLE
proto_err  out  1  sticky: simultaneous s_read and s_write seen in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; m_read=m_write=0; m_address=0; m_writedata=0; m_byteenable=0; s_readdatavalid=0; s_readdata=0; proto_err=0; beat counter=0.
- Reset mid-burst returns to IDLE immediately and discards all remaining beats.
- Registered m_* outputs. Combinational s_waitrequest: low only in IDLE and WR_FETCH, high elsewhere.
- IDLE:
  - s_write: latch address, data, byteenable; remaining = max(burstcount,1)-1; go WR_ISSUE.
  - s_read (without s_write): latch address; remaining = max(burstcount,1); go RD_ISSUE.
  - Both asserted: write wins, the read is dropped, proto_err is set and stays set until reset.
- WR_ISSUE:
  - m_write=1 with the latched beat and m_address.
  - On m_waitrequest=0 (accepted): m_write<=0; if remaining==0 go IDLE, else address+1 (mod 2^ADDR_W) and go WR_FETCH.
- WR_FETCH:
  - s_waitrequest=0. Wait for s_write, then latch data/byteenable, remaining-1, go WR_ISSUE.
  - s_read arriving here is not accepted.
- RD_ISSUE: m_read=1, m_byteenable=4'hF. On m_waitrequest=0: m_read<=0, go RD_WAIT.
- RD_WAIT:
  - On m_readdatavalid: s_readdata<=m_readdata and s_readdatavalid<=1 the next cycle (1-cycle latency); remaining-1.
  - If remaining was 1 go IDLE, else address+1 and go RD_ISSUE.
  - m_readdatavalid is ignored outside RD_WAIT.
- Request deassertion: after acceptance, m_read/m_write deassert the next cycle, so the bridge never sees a request re-sampled.
- Throughput: minimum 1 idle cycle between downstream transactions. No timeout here; the bridge returns FFFFFFFF on its own timeout, and that value is forwarded unchanged.
- Address wrap: 3FFFFFFF+1 -> 00000000 with no error.

Test Plan:
- Single read, burstcount=1, addr 0x0000_1000, bridge returns 0xDEADBEEF after 5 cycles -> one m_read at 0x1000; s_readdatavalid=1 with 0xDEADBEEF exactly 1 cycle after m_readdatavalid; busy falls the same cycle.
- Read burst of 4 at 0x3FFFFFFE -> m_address sequence 3FFFFFFE, 3FFFFFFF, 00000000, 00000001; exactly 4 s_readdatavalid pulses, in order.
- Write burst of 3 (data 11,22,33; byteenable F,3,C) with bridge waitrequest held 4 cycles per beat -> 3 m_write acceptances at A, A+1, A+2 with matching data/byteenable; s_waitrequest low only in IDLE/WR_FETCH.
- burstcount=0 write -> treated as one beat; returns to IDLE; no WR_FETCH visit.
- s_read and s_write together in IDLE -> write serviced, no m_read issued, proto_err=1 and held through later traffic until rst_n.
- rst_n asserted during read burst beat 2 of 4 -> all outputs at reset values asynchronously; next burst after release completes normally.
